// File: rtl/fb_pkg.sv
// Framebuffer constants, write-FSM state encoding and the pixel FIFO word
// shared by the line-drawing and video readout paths.
package fb_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] colour;
    } fb_pixel_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is visible on rdata
// whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // decide which entries are valid, so clearing the RAM would buy nothing.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Buffers (x, y, colour) requests and commits each as a timed SRAM write while
// the arbiter grants the bus. Define PIXEL_WRITER_CLIP_COUNT_EN for clip_count.
module pixel_writer
    import fb_pkg::*;
#(
    parameter int H_RES      = fb_pkg::H_RES,
    parameter int V_RES      = fb_pkg::V_RES,
    parameter int ADDR_W     = fb_pkg::ADDR_W,
    parameter int DATA_W     = fb_pkg::DATA_W,
    parameter int FIFO_DEPTH = 8,
    parameter int WE_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [DATA_W-1:0] pix_colour,
    input  logic              mem_gnt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we_n,
    output logic              busy,
    output logic [15:0]       clip_count
);

    localparam int WCNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    wr_state_t         state;
    logic [WCNT_W-1:0] we_cnt;
    logic [ADDR_W-1:0] pix_addr;
    fb_pixel_t         push_word;
    fb_pixel_t         head;
    logic              clipped;
    logic              accept;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    generate
        if (H_RES == 640) begin : g_addr_640
            assign pix_addr = (ADDR_W'(pix_y) << 9) + (ADDR_W'(pix_y) << 7) + ADDR_W'(pix_x);
        end else begin : g_addr_mul
            assign pix_addr = ADDR_W'(pix_y) * ADDR_W'(H_RES) + ADDR_W'(pix_x);
        end
    endgenerate

    always_comb begin
        // NOTE: defaults first on every path so this block can never infer a latch.
        clipped   = 1'b0;
        push_word = '{addr: pix_addr, colour: pix_colour};
        if (int'(pix_x) >= H_RES || int'(pix_y) >= V_RES)
            clipped = 1'b1;
    end

    assign pix_ready = !fifo_full && !reset;
    assign accept    = pix_valid && pix_ready;
    // The HOLD cycle doubles as the idle decision so back-to-back writes cost WE_CYCLES+2.
    assign pop       = !fifo_empty && mem_gnt && (state == IDLE || state == HOLD);
    assign busy      = !fifo_empty || (state != IDLE);
    assign mem_req   = busy;

    sync_fifo #(
        .WIDTH ($bits(fb_pixel_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept && !clipped),
        .wdata (push_word),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (reset) begin
            state     <= IDLE;
            we_cnt    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we_n  <= 1'b1;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (pop) begin
                        mem_addr  <= head.addr;
                        mem_wdata <= head.colour;
                        state     <= SETUP;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    mem_we_n <= 1'b0;
                    we_cnt   <= WCNT_W'(WE_CYCLES - 1);
                    state    <= STROBE;
                end
                STROBE: begin
                    if (we_cnt == '0) begin
                        mem_we_n <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        we_cnt <= we_cnt - WCNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIXEL_WRITER_CLIP_COUNT_EN
    logic [15:0] clip_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            clip_cnt_q <= '0;
        else if (accept && clipped && clip_cnt_q != 16'hFFFF)
            clip_cnt_q <= clip_cnt_q + 16'd1;
    end

    assign clip_count = clip_cnt_q;
`else
    assign clip_count = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: stimulus queues expected SRAM writes,
// a monitor decodes mem_we_n pulses and checks them in order.
module tb_pixel_writer;

    localparam int WE_CYCLES = 2;
`ifdef PIXEL_WRITER_CLIP_COUNT_EN
    localparam int CLIP_EXP = 2;
`else
    localparam int CLIP_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [7:0]  pix_colour = '0;
    logic        mem_gnt = 1'b0;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we_n;
    logic        busy;
    logic [15:0] clip_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    logic [26:0] exp_q[$];
    int          wr_starts[$];
    logic [18:0] last_addr = '0;

    pixel_writer #(.WE_CYCLES(WE_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .mem_gnt    (mem_gnt),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we_n   (mem_we_n),
        .busy       (busy),
        .clip_count (clip_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Called at a negedge; leaves pix_valid high so callers can stream.
    task automatic push(input int x, input int y, input logic [7:0] c);
        int t = 0;
        pix_x      = x[9:0];
        pix_y      = y[9:0];
        pix_colour = c;
        pix_valid  = 1'b1;
        while (!pix_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) begin
            check("push_ready_timeout", 32'(pix_ready), 1);
            pix_valid = 1'b0;
            return;
        end
        if (x < 640 && y < 480)
            exp_q.push_back({19'(y * 640 + x), c});
        @(posedge clk);
        @(negedge clk);
        hs_cyc = cyc;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_we_low(input string name);
        int t = 0;
        while (mem_we_n && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(mem_we_n), 0);
    endtask

    // Monitor: samples just after each rising edge, one record per write pulse.
    initial begin : monitor
        logic        in_wr;
        int          lo;
        logic [18:0] a;
        logic [7:0]  d;
        logic [26:0] e;
        in_wr = 1'b0;
        lo    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                in_wr = 1'b0;
                lo    = 0;
                continue;
            end
            if (!mem_we_n) begin
                if (!in_wr) begin
                    in_wr = 1'b1;
                    lo    = 0;
                    a     = mem_addr;
                    d     = mem_wdata;
                    wr_starts.push_back(cyc);
                end else begin
                    check("strobe_addr_stable", 32'(mem_addr), 32'(a));
                    check("strobe_data_stable", 32'(mem_wdata), 32'(d));
                end
                lo++;
            end else if (in_wr) begin
                in_wr = 1'b0;
                last_addr = a;
                check("we_low_cycles", 32'(lo), WE_CYCLES);
                check("hold_addr_stable", 32'(mem_addr), 32'(a));
                check("write_was_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(a), 32'(e[26:8]));
                    check("write_data", 32'(d), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pix_ready", 32'(pix_ready), 0);
        check("rst_mem_we_n", 32'(mem_we_n), 1);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_clip_count", 32'(clip_count), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_pix_ready", 32'(pix_ready), 1);

        // Single pixel with grant: 2-cycle latency to strobe
        mem_gnt = 1'b1;
        wr_starts.delete();
        push(3, 2, 8'h5A);
        pix_valid = 1'b0;
        wait_idle("single_idle");
        check("single_write_count", 32'(wr_starts.size()), 1);
        if (wr_starts.size() > 0)
            check("single_latency", 32'(wr_starts[0] - hs_cyc), 2);
        check("single_addr", 32'(last_addr), 1283);

        // Grant withheld: fill the FIFO, then drain back-to-back
        mem_gnt = 1'b0;
        wr_starts.delete();
        for (int i = 0; i < 8; i++)
            push(10 + i, 100 + 3 * i, 8'(8'h10 + i));
        check("withheld_ready_full", 32'(pix_ready), 0);
        pix_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("withheld_we_n", 32'(mem_we_n), 1);
        check("withheld_no_writes", 32'(wr_starts.size()), 0);
        check("withheld_mem_req", 32'(mem_req), 1);
        mem_gnt = 1'b1;
        wait_idle("withheld_idle");
        check("withheld_write_count", 32'(wr_starts.size()), 8);
        for (int i = 1; i < wr_starts.size(); i++)
            check("withheld_spacing", 32'(wr_starts[i] - wr_starts[i-1]), 4);

        // Clipping: two dropped, one corner pixel written
        wr_starts.delete();
        push(640, 0, 8'hA1);
        push(0, 480, 8'hA2);
        push(639, 479, 8'hA3);
        pix_valid = 1'b0;
        wait_idle("clip_idle");
        check("clip_write_count", 32'(wr_starts.size()), 1);
        check("clip_corner_addr", 32'(last_addr), 307199);
        check("clip_count", 32'(clip_count), CLIP_EXP);

        // Grant drop mid-access
        wr_starts.delete();
        push(7, 7, 8'hC3);
        pix_valid = 1'b0;
        wait_we_low("gdrop_we_low");
        mem_gnt = 1'b0;
        push(8, 7, 8'hC4);
        pix_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("gdrop_one_write", 32'(wr_starts.size()), 1);
        check("gdrop_we_n_idle", 32'(mem_we_n), 1);
        check("gdrop_req_pending", 32'(mem_req), 1);
        mem_gnt = 1'b1;
        wait_idle("gdrop_idle");
        check("gdrop_two_writes", 32'(wr_starts.size()), 2);

        // Reset mid-write with a second pixel queued
        push(20, 30, 8'hE1);
        push(21, 30, 8'hE2);
        pix_valid = 1'b0;
        wait_we_low("rstmid_we_low");
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_we_n", 32'(mem_we_n), 1);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_ready_low", 32'(pix_ready), 0);
        check("rstmid_clip_clear", 32'(clip_count), 0);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_ready_high", 32'(pix_ready), 1);
        wr_starts.delete();
        repeat (8) @(negedge clk);
        check("rstmid_fifo_flushed", 32'(wr_starts.size()), 0);
        check("rstmid_mem_req", 32'(mem_req), 0);

        // Streaming diagonal with pix_valid held high
        wr_starts.delete();
        for (int i = 0; i < 20; i++)
            push(i * 20, i * 20 + 5, 8'(i * 13 + 7));
        pix_valid = 1'b0;
        wait_idle("stream_idle");
        n = wr_starts.size();
        check("stream_write_count", 32'(n), 20);
        check("stream_last_addr", 32'(last_addr), 32'(385 * 640 + 380));

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Consumer end of the line-drawing path: accepts (x, y, colour) pixel requests and commits them to the external asynchronous framebuffer SRAM.
- Requests arrive on a valid/ready handshake from the line generator.
- Requests are buffered in a small FIFO so line drawing is not stalled while the video readout owns the SRAM bus.
- Each pixel becomes one multi-cycle SRAM write, performed only while the bus arbiter grants access.

Parameters:
- H_RES, 640, framebuffer width in pixels; also the row stride.
- V_RES, 480, framebuffer height in pixels.
- ADDR_W, 19, SRAM address width.
- DATA_W, 8, colour/SRAM data width.
- FIFO_DEPTH, 8, pixel request FIFO entries; must be a power of two, at least 2.
- WE_CYCLES, 2, clocks that mem_we_n is held low per write; at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- pix_valid  in  1  pixel request valid.
- pix_ready  out  1  FIFO can accept a request.
- pix_x  in  10  pixel column.
- pix_y  in  10  pixel row.
- pix_colour  in  DATA_W  pixel value.
- mem_gnt  in  1  arbiter grants SRAM bus to this block.
- mem_req  out  1  block has pending work and wants the bus.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_we_n  out  1  SRAM write enable, active-low.
- busy  out  1  FIFO non-empty or write in progress.
- clip_count  out  16  clipped-pixel counter; see Optional Feature.

Behaviour:
- Reset: FIFO emptied, FSM to IDLE, pix_ready=0 during reset then 1, mem_req=0, mem_addr=0, mem_wdata=0, mem_we_n=1, busy=0, clip_count=0.
- Reset mid-write forces mem_we_n=1 on the next edge and abandons the access.
- Handshake: a transfer occurs on a clk edge with pix_valid and pix_ready both high.
- pix_ready = !full; it is registered-free, derived from FIFO occupancy.
- Simultaneous push and pop when full is not allowed: ready is low, so no push.
- Simultaneous push and pop when empty: the push lands and the pop waits one cycle. There is no bypass; minimum latency is handshake to mem_we_n falling = 2 cycles.
- Clipping at push time: if pix_x >= H_RES or pix_y >= V_RES, the request is accepted (handshake completes) but is not stored. It is counted per Optional Feature.
- Address: mem_addr = pix_y*H_RES + pix_x, computed at push and stored in the FIFO entry alongside colour. For H_RES=640 it is implemented as (y<<9)+(y<<7)+x, zero-extended to ADDR_W, with no truncation.
- mem_req = FIFO non-empty OR FSM != IDLE.
- FSM:
  - IDLE: when FIFO is non-empty and mem_gnt=1, pop the head, latch mem_addr/mem_wdata, go to SETUP.
  - SETUP: mem_we_n=1, address/data stable (1 cycle); go to STROBE.
  - STROBE: mem_we_n=0 for WE_CYCLES cycles (down-counter); then go to HOLD.
  - HOLD: mem_we_n=1, address/data held (1 cycle); go to IDLE.
  - Per-pixel cost is WE_CYCLES+2 cycles. Back-to-back pixels are allowed directly from HOLD into IDLE→SETUP.
- Grant rules:
  - mem_gnt is sampled only in IDLE.
  - Once SETUP is entered, the access completes even if mem_gnt drops; the arbiter must not revoke mid-access.
  - mem_gnt low in IDLE holds the FIFO contents indefinitely; nothing is lost.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty come from the MSB compare and wrap naturally.
- busy falls in the cycle after the final HOLD when the FIFO is empty.

Optional Feature:
- Macro: PIXEL_WRITER_CLIP_COUNT_EN.
- With it defined: clip_count increments by 1 per clipped accepted request and saturates at 16'hFFFF. It is cleared only by reset.
- Without it: clip_count is constant 0, no counter logic is generated, and clipped pixels are still silently dropped.

Decomposition:
- Shared package (fb_pkg): H_RES, V_RES, ADDR_W, DATA_W defaults, the FSM state encoding (IDLE/SETUP/STROBE/HOLD), and an fb_pixel_t struct {addr, colour} used as the FIFO word.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty). It is reusable by the video readout path.

Test Plan:
- Single pixel: push (x=3, y=2, colour=8'h5A) with mem_gnt=1 → mem_addr=1283, mem_wdata=8'h5A, mem_we_n low exactly 2 cycles; busy returns to 0 after HOLD.
- Grant withheld: mem_gnt=0, push 8 pixels → pix_ready=0 after the 8th, mem_we_n stays 1. Raise mem_gnt → 8 writes in push order, 4 cycles each.
- Clipping: push (640,0), (0,480), then (639,479) → only one write, mem_addr=307199; clip_count=2 with the macro, 0 without.
- Grant drop mid-access: drop mem_gnt during STROBE → the write still completes with full WE_CYCLES, and no further pop occurs until mem_gnt returns.
- Reset mid-write: assert reset in STROBE → next cycle mem_we_n=1, busy=0, FIFO empty, pix_ready=1 after reset releases.
- Streaming: pix_valid held high for 20 pixels along a diagonal with mem_gnt=1 → all 20 addresses written in order and no handshake lost when ready toggles.
